// File: rtl/pipe_decoder.sv
// Decode stage: register file, immediate/destination decode and a one-deep output register (1-cycle latency).
// Stalls upstream when the output is held (out_ready=0) or on a load-use hazard, which inserts one bubble.
module pipe_decoder #(
  parameter int          DATA_W    = 32,
  parameter logic [31:0] SP_INIT   = 32'h0000_7FFC,
  parameter bit          BYPASS_EN = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       Instruction,
  input  logic [31:0]       opcplus4,
  input  logic              Jal,
  input  logic              RegDst,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  input  logic              MemRead,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  output logic [DATA_W-1:0] Sign_extend,
  output logic [DATA_W-1:0] out_pc4,
  output logic [4:0]        out_dest,
  output logic              out_RegWrite,
  output logic              out_MemtoReg,
  output logic              out_MemRead,
  output logic              out_Jal
);

  localparam logic [DATA_W-1:0] SP_RESET = DATA_W'(SP_INIT);

  logic [DATA_W-1:0] regs [32];
  logic [5:0]        opcode;
  logic [4:0]        rs, rt, dest;
  logic [15:0]       imm;
  logic [DATA_W-1:0] rd1, rd2, imm_ext;
  logic              adv, hz, capture;

  assign opcode = Instruction[31:26];
  assign rs     = Instruction[25:21];
  assign rt     = Instruction[20:16];
  assign imm    = Instruction[15:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= (i == 29) ? SP_RESET : '0;
      end
    end else if (wb_en && wb_addr != 5'd0) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Same-cycle write-back is visible to the read only when bypass is enabled.
  always_comb begin
    rd1 = regs[rs];
    rd2 = regs[rt];
    if (BYPASS_EN && wb_en && wb_addr == rs) rd1 = wb_data;
    if (BYPASS_EN && wb_en && wb_addr == rt) rd2 = wb_data;
    if (rs == 5'd0) rd1 = '0;
    if (rt == 5'd0) rd2 = '0;
  end

  // andi/ori/xori zero-extend; every other opcode sign-extends.
  always_comb begin
    if (opcode == 6'h0C || opcode == 6'h0D || opcode == 6'h0E) begin
      imm_ext = {{(DATA_W-16){1'b0}}, imm};
    end else begin
      imm_ext = {{(DATA_W-16){imm[15]}}, imm};
    end
  end

  always_comb begin
    if (Jal)         dest = 5'd31;
    else if (RegDst) dest = Instruction[15:11];
    else             dest = rt;
  end

  assign adv      = ~out_valid | out_ready;
  assign hz       = in_valid & out_valid & out_MemRead & (out_dest != 5'd0) &
                    ((out_dest == rs) | (out_dest == rt));
  assign in_ready = adv & ~hz;
  assign capture  = adv & in_valid & ~hz;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid    <= 1'b0;
      read_data_1  <= '0;
      read_data_2  <= '0;
      Sign_extend  <= '0;
      out_pc4      <= '0;
      out_dest     <= '0;
      out_RegWrite <= 1'b0;
      out_MemtoReg <= 1'b0;
      out_MemRead  <= 1'b0;
      out_Jal      <= 1'b0;
    end else if (adv) begin
      out_valid <= capture;
      if (capture) begin
        read_data_1  <= rd1;
        read_data_2  <= rd2;
        Sign_extend  <= imm_ext;
        out_pc4      <= DATA_W'(opcplus4);
        out_dest     <= dest;
        out_RegWrite <= RegWrite;
        out_MemtoReg <= MemtoReg;
        out_MemRead  <= MemRead;
        out_Jal      <= Jal;
      end
    end
  end

endmodule

// File: tb/tb_pipe_decoder.sv
// Directed bench for pipe_decoder: one bypassing and one non-bypassing instance share all inputs.
module tb_pipe_decoder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] Instruction = '0;
  logic [31:0] opcplus4 = '0;
  logic        Jal = 1'b0, RegDst = 1'b0, RegWrite = 1'b0, MemtoReg = 1'b0, MemRead = 1'b0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        out_ready = 1'b1;

  logic        a_in_ready, a_out_valid, a_rw, a_mtr, a_mr, a_jal;
  logic [31:0] a_rd1, a_rd2, a_se, a_pc4;
  logic [4:0]  a_dest;
  logic        b_in_ready, b_out_valid, b_rw, b_mtr, b_mr, b_jal;
  logic [31:0] b_rd1, b_rd2, b_se, b_pc4;
  logic [4:0]  b_dest;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  pipe_decoder #(.DATA_W(32), .SP_INIT(32'h0000_7FFC), .BYPASS_EN(1'b1)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .Instruction(Instruction), .opcplus4(opcplus4), .Jal(Jal), .RegDst(RegDst),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .MemRead(MemRead),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .read_data_1(a_rd1), .read_data_2(a_rd2), .Sign_extend(a_se), .out_pc4(a_pc4),
    .out_dest(a_dest), .out_RegWrite(a_rw), .out_MemtoReg(a_mtr), .out_MemRead(a_mr),
    .out_Jal(a_jal));

  pipe_decoder #(.DATA_W(32), .SP_INIT(32'h0000_7FFC), .BYPASS_EN(1'b0)) dut_nb (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .Instruction(Instruction), .opcplus4(opcplus4), .Jal(Jal), .RegDst(RegDst),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .MemRead(MemRead),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .read_data_1(b_rd1), .read_data_2(b_rd2), .Sign_extend(b_se), .out_pc4(b_pc4),
    .out_dest(b_dest), .out_RegWrite(b_rw), .out_MemtoReg(b_mtr), .out_MemRead(b_mr),
    .out_Jal(b_jal));

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rs, rt;
    logic [15:0] imm;
    logic        jal, regdst;
    logic [2:0]  ctl;      // {RegWrite, MemtoReg, MemRead}
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata, pc4;
    logic [31:0] e_rd1, e_rd2, e_rd1_nb, e_rd2_nb, e_se;
    logic [4:0]  e_dest;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [15:0] imm, input logic jal, input logic regdst,
                       input logic [2:0] ctl, input logic [31:0] pc4);
    in_valid    = 1'b1;
    Instruction = {op, rs, rt, imm};
    Jal         = jal;
    RegDst      = regdst;
    {RegWrite, MemtoReg, MemRead} = ctl;
    opcplus4    = pc4;
  endtask

  initial begin
    // op   rs  rt  imm      jal regdst ctl    wen waddr wdata          pc4        rd1            rd2            rd1_nb         rd2_nb         se
    tbl[0] = '{6'h00, 5'd29, 5'd0,  16'h1800, 1'b0, 1'b1, 3'b100, 1'b0, 5'd0,  32'h0,          32'h0000_0104, 32'h0000_7FFC, 32'h0,         32'h0000_7FFC, 32'h0,         32'h0000_1800, 5'd3};
    tbl[1] = '{6'h08, 5'd5,  5'd6,  16'h0010, 1'b0, 1'b0, 3'b100, 1'b1, 5'd5,  32'hDEAD_BEEF, 32'h0000_0108, 32'hDEAD_BEEF, 32'h0,         32'h0,         32'h0,         32'h0000_0010, 5'd6};
    tbl[2] = '{6'h0D, 5'd5,  5'd0,  16'h8000, 1'b0, 1'b0, 3'b100, 1'b1, 5'd0,  32'h1234_5678, 32'h0000_010C, 32'hDEAD_BEEF, 32'h0,         32'hDEAD_BEEF, 32'h0,         32'h0000_8000, 5'd0};
    tbl[3] = '{6'h08, 5'd0,  5'd9,  16'h8000, 1'b0, 1'b0, 3'b100, 1'b1, 5'd9,  32'h0000_00AA, 32'h0000_0110, 32'h0,         32'h0000_00AA, 32'h0,         32'h0,         32'hFFFF_8000, 5'd9};
    tbl[4] = '{6'h03, 5'd9,  5'd5,  16'h0040, 1'b1, 1'b0, 3'b100, 1'b0, 5'd0,  32'h0,          32'h0000_2004, 32'h0000_00AA, 32'hDEAD_BEEF, 32'h0000_00AA, 32'hDEAD_BEEF, 32'h0000_0040, 5'd31};
    tbl[5] = '{6'h0C, 5'd9,  5'd5,  16'hFFFF, 1'b0, 1'b0, 3'b000, 1'b0, 5'd0,  32'h0,          32'h0000_0118, 32'h0000_00AA, 32'hDEAD_BEEF, 32'h0000_00AA, 32'hDEAD_BEEF, 32'h0000_FFFF, 5'd5};
    tbl[6] = '{6'h0E, 5'd29, 5'd29, 16'h8001, 1'b0, 1'b0, 3'b100, 1'b1, 5'd29, 32'h0000_1000, 32'h0000_011C, 32'h0000_1000, 32'h0000_1000, 32'h0000_7FFC, 32'h0000_7FFC, 32'h0000_8001, 5'd29};
    tbl[7] = '{6'h00, 5'd29, 5'd5,  16'h5020, 1'b0, 1'b1, 3'b110, 1'b0, 5'd0,  32'h0,          32'h0000_0120, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0000_5020, 5'd10};
    tbl[8] = '{6'h03, 5'd0,  5'd0,  16'h1000, 1'b1, 1'b1, 3'b100, 1'b0, 5'd0,  32'h0,          32'hFFFF_FFFC, 32'h0,         32'h0,         32'h0,         32'h0,         32'h0000_1000, 5'd31};
    tbl[9] = '{6'h0F, 5'd0,  5'd4,  16'h9000, 1'b0, 1'b0, 3'b100, 1'b0, 5'd0,  32'h0,          32'h0000_0128, 32'h0,         32'h0,         32'h0,         32'h0,         32'hFFFF_9000, 5'd4};

    #12;
    chk("reset out_valid", {30'd0, a_out_valid, b_out_valid}, 32'h0);
    chk("reset read_data_1", a_rd1, 32'h0);
    chk("reset Sign_extend", a_se, 32'h0);
    chk("reset out_dest", {27'd0, a_dest}, 32'h0);
    chk("reset ctl", {28'd0, a_rw, a_mtr, a_mr, a_jal}, 32'h0);

    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].imm, tbl[i].jal, tbl[i].regdst, tbl[i].ctl, tbl[i].pc4);
      wb_en = tbl[i].wen; wb_addr = tbl[i].waddr; wb_data = tbl[i].wdata;
      #1;
      chk($sformatf("v%0d in_ready", i), {30'd0, a_in_ready, b_in_ready}, 32'h3);
      @(negedge clock);
      chk($sformatf("v%0d out_valid", i), {30'd0, a_out_valid, b_out_valid}, 32'h3);
      chk($sformatf("v%0d read_data_1", i), a_rd1, tbl[i].e_rd1);
      chk($sformatf("v%0d read_data_2", i), a_rd2, tbl[i].e_rd2);
      chk($sformatf("v%0d nb read_data_1", i), b_rd1, tbl[i].e_rd1_nb);
      chk($sformatf("v%0d nb read_data_2", i), b_rd2, tbl[i].e_rd2_nb);
      chk($sformatf("v%0d Sign_extend", i), a_se, tbl[i].e_se);
      chk($sformatf("v%0d out_dest", i), {27'd0, a_dest}, {27'd0, tbl[i].e_dest});
      chk($sformatf("v%0d out_pc4", i), a_pc4, tbl[i].pc4);
      chk($sformatf("v%0d ctl", i), {28'd0, a_rw, a_mtr, a_mr, a_jal}, {28'd0, tbl[i].ctl, tbl[i].jal});
    end
    wb_en = 1'b0;

    // Load-use: lw $8 then add reading $8 -> one bubble.
    drive(6'h23, 5'd0, 5'd8, 16'h0000, 1'b0, 1'b0, 3'b111, 32'h200);
    #1 chk("lw in_ready", {31'd0, a_in_ready}, 32'h1);
    @(negedge clock);
    chk("lw out", {26'd0, a_out_valid, a_mr, a_dest}, {26'd0, 1'b1, 1'b1, 5'd8});
    drive(6'h00, 5'd8, 5'd10, {5'd11, 11'h020}, 1'b0, 1'b1, 3'b100, 32'h204);
    #1 chk("hazard in_ready", {30'd0, a_in_ready, b_in_ready}, 32'h0);
    @(negedge clock);
    chk("bubble out_valid", {31'd0, a_out_valid}, 32'h0);
    chk("bubble dest hold", {27'd0, a_dest}, 32'd8);
    #1 chk("after bubble in_ready", {31'd0, a_in_ready}, 32'h1);
    @(negedge clock);
    chk("add out", {26'd0, a_out_valid, a_mr, a_dest}, {26'd0, 1'b1, 1'b0, 5'd11});
    chk("add pc4", a_pc4, 32'h204);

    // Downstream backpressure for 3 cycles.
    drive(6'h08, 5'd29, 5'd12, 16'h0005, 1'b0, 1'b0, 3'b100, 32'h300);
    @(negedge clock);
    chk("bp A dest", {27'd0, a_dest}, 32'd12);
    out_ready = 1'b0;
    drive(6'h08, 5'd0, 5'd13, 16'h0007, 1'b0, 1'b0, 3'b100, 32'h304);
    for (int c = 0; c < 3; c++) begin
      #1 chk($sformatf("bp%0d in_ready", c), {31'd0, a_in_ready}, 32'h0);
      @(negedge clock);
      chk($sformatf("bp%0d hold", c), {26'd0, a_out_valid, a_dest}, {26'd0, 1'b1, 5'd12});
      chk($sformatf("bp%0d hold se", c), a_se, 32'h5);
    end
    out_ready = 1'b1;
    #1 chk("bp release in_ready", {31'd0, a_in_ready}, 32'h1);
    @(negedge clock);
    chk("bp B captured", {26'd0, a_out_valid, a_dest}, {26'd0, 1'b1, 5'd13});
    chk("bp B se", a_se, 32'h7);

    // Reset asserted in the middle of a hazard stall.
    drive(6'h23, 5'd0, 5'd14, 16'h0000, 1'b0, 1'b0, 3'b111, 32'h400);
    wb_en = 1'b1; wb_addr = 5'd20; wb_data = 32'h55;
    @(negedge clock);
    wb_en = 1'b0;
    drive(6'h00, 5'd14, 5'd0, 16'h0000, 1'b0, 1'b1, 3'b100, 32'h404);
    #1 chk("rst stall in_ready", {31'd0, a_in_ready}, 32'h0);
    #1 reset = 1'b1;
    #1;
    chk("rst async out_valid", {30'd0, a_out_valid, b_out_valid}, 32'h0);
    chk("rst async dest/ctl", {23'd0, a_dest, a_rw, a_mtr, a_mr, a_jal}, 32'h0);
    chk("rst async pc4", a_pc4, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    drive(6'h00, 5'd29, 5'd20, 16'h0000, 1'b0, 1'b0, 3'b100, 32'h500);
    @(negedge clock);
    chk("post-rst out_valid", {31'd0, a_out_valid}, 32'h1);
    chk("post-rst rd1 sp", a_rd1, 32'h0000_7FFC);
    chk("post-rst rd2 r20", a_rd2, 32'h0);
    in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_decoder.md
PIPE_DECODER -- requirements
Module: pipe_decoder

Interface
REQ-001 Parameter DATA_W, 32, datapath/register width; SHALL be >= 32.
REQ-002 Parameter SP_INIT, 32'h0000_7FFC, reset value of register 29, zero-extended to DATA_W.
REQ-003 Parameter BYPASS_EN, 1, 1 = same-cycle write-back forwarded to reads, 0 = reads return the stored value only.
REQ-004 Port clock  in  1  single clock; all state on rising edge.
REQ-005 Port reset  in  1  asynchronous, active-high reset.
REQ-006 Ports in_valid in 1, in_ready out 1: upstream handshake; Instruction in 32, opcplus4 in 32.
REQ-007 Ports Jal, RegDst, RegWrite, MemtoReg, MemRead  in  1 each: control for the incoming instruction.
REQ-008 Ports wb_en in 1, wb_addr in 5, wb_data in DATA_W: register-file write port.
REQ-009 Ports out_valid out 1, out_ready in 1: downstream handshake.
REQ-010 Outputs read_data_1, read_data_2, Sign_extend, out_pc4 (DATA_W each); out_dest (5); out_RegWrite, out_MemtoReg, out_MemRead, out_Jal (1 each); all registered.

Function
REQ-011 Register file: 32 x DATA_W; register 0 reads 0, and writes to it are ignored.
REQ-012 Write on rising clock when wb_en=1 and wb_addr!=0.
REQ-013 Reads combinational: rs = Instruction[25:21], rt = Instruction[20:16]; with BYPASS_EN=1, wb_en=1 and wb_addr==addr!=0 return wb_data.
REQ-014 Immediate: opcode (Instruction[31:26]) 0x0C/0x0D/0x0E zero-extend Instruction[15:0]; all other opcodes sign-extend to DATA_W.
REQ-015 Destination: Jal=1 -> 31; else RegDst=1 -> Instruction[15:11]; else Instruction[20:16].
REQ-016 Jal=1: captured read_data_2 unchanged; out_pc4 = opcplus4 zero-extended, for downstream link write.
REQ-017 Pipeline advance: adv = ~out_valid | out_ready.
REQ-018 Load-use hazard: hz = in_valid & out_valid & out_MemRead & out_dest!=0 & (out_dest==rs | out_dest==rt).
REQ-019 in_ready = adv & ~hz, combinational.
REQ-020 On adv & in_valid & ~hz: capture all outputs; out_valid<=1.
REQ-021 On adv & (hz | ~in_valid): out_valid<=0 (bubble); data outputs hold.
REQ-022 On ~adv: all outputs hold; no capture regardless of in_valid.
REQ-023 Hazard stall lasts exactly one accepted bubble; the next cycle re-evaluates hz against the new out_* state.
REQ-024 A write-back and a capture of the same register in one cycle: BYPASS_EN=1 -> new value captured; BYPASS_EN=0 -> old value captured.
REQ-025 Latency: one cycle from accepted input to out_valid.

Reset
REQ-026 reset=1 asynchronously clears registers 1..31 to 0 except register 29 = SP_INIT.
REQ-027 reset=1 clears out_valid and every registered output to 0; in-flight instruction discarded.
REQ-028 Handshakes and writes are ignored while reset=1; operation starts on the first rising edge after deassertion.

Verification
REQ-029 Reset, then read rs=29, rt=0 -> read_data_1=32'h0000_7FFC, read_data_2=0.
REQ-030 wb_en=1, addr=5, data=0xDEAD_BEEF in the same cycle as accepting rs=5 -> BYPASS_EN=1 captures 0xDEADBEEF; BYPASS_EN=0 captures 0.
REQ-031 lw writing $8 accepted, then add reading $8 -> in_ready=0 for one cycle, one bubble (out_valid=0), add accepted next cycle.
REQ-032 out_ready=0 for 3 cycles with out_valid=1 -> outputs stable, in_ready=0; out_ready=1 -> next instruction captured.
REQ-033 ori imm=0x8000 -> Sign_extend=0x0000_8000; addi imm=0x8000 -> 0xFFFF_8000; jal -> out_dest=31, out_pc4=opcplus4.
REQ-034 reset asserted mid-stall -> out_valid=0 immediately (asynchronous), registers at reset values.
